// File: rtl/uart_cmd_receiver.sv
// UART receiver with 3-sample majority voting, optional parity and a small
// command decoder that turns recognised ASCII bytes into a 3-bit route code.
module uart_cmd_receiver #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0
) (
    input  logic                 inclk,
    input  logic                 rst_n,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic [2:0]           c_s,
    output logic                 cmd_strobe
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PH_W    = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]  PH_S0    = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0]  PH_S2    = PH_W'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

    state_t                 state, state_nx;
    logic                   rx_m, rx_s, rx_prev;
    logic [1:0]             settle;
    logic                   fall;
    logic [DIV_W-1:0]       div_cnt;
    logic                   tick;
    logic [PH_W-1:0]        phase;
    logic                   ph_clr;
    logic                   s0, s1, armed;
    logic                   maj, decide;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_ok;
    logic                   load_data, valid_nx, ferr_nx, perr_nx;
    logic [7:0]             byte_ext;
    logic [2:0]             cmd_code;
    logic                   cmd_hit;

    // Edges are only trusted once the synchroniser holds real line samples,
    // so a line that is low when reset releases is not mistaken for a start.
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            settle  <= 2'd0;
        end else begin
            rx_m    <= Rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
            if (settle != 2'd3)
                settle <= settle + 2'd1;
        end
    end

    assign fall = (settle == 2'd3) && rx_prev && !rx_s;
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // In WAIT_IDLE the phase counter doubles as the "line high" tick counter.
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n)
            phase <= '0;
        else if (ph_clr)
            phase <= '0;
        else if (tick) begin
            if ((state == WAIT_IDLE) && !rx_s)
                phase <= '0;
            else if (phase == PH_LAST)
                phase <= '0;
            else
                phase <= phase + 1'b1;
        end
    end

    assign maj    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign decide = tick && (phase == PH_S2) && armed;

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            s0      <= 1'b1;
            s1      <= 1'b1;
            armed   <= 1'b0;
            bit_cnt <= 4'd0;
            shreg   <= '0;
            par_ok  <= 1'b1;
        end else begin
            if (tick && (phase == PH_S0))
                s0 <= rx_s;
            if (tick && (phase == PH_MID))
                s1 <= rx_s;
            if ((state == IDLE) || (state == START))
                armed <= 1'b0;
            else if (tick && (phase == PH_S0))
                armed <= 1'b1;
            else if (decide)
                armed <= 1'b0;
            if (state != DATA)
                bit_cnt <= 4'd0;
            else if (decide)
                bit_cnt <= bit_cnt + 4'd1;
            if ((state == DATA) && decide)
                shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (state == START)
                par_ok <= 1'b1;
            else if ((state == PAR) && decide)
                par_ok <= (PARITY == 1) ? (^{shreg, maj}) : ~(^{shreg, maj});
        end
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        ph_clr    = 1'b0;
        load_data = 1'b0;
        valid_nx  = 1'b0;
        ferr_nx   = 1'b0;
        perr_nx   = 1'b0;
        case (state)
            IDLE: begin
                ph_clr = 1'b1;
                if (fall)
                    state_nx = START;
            end
            START: begin
                if (tick && (phase == PH_MID))
                    state_nx = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (decide && (bit_cnt == BIT_LAST))
                    state_nx = (PARITY != 0) ? PAR : STOP;
            end
            PAR: begin
                if (decide)
                    state_nx = STOP;
            end
            STOP: begin
                if (decide) begin
                    if (maj) begin
                        load_data = 1'b1;
                        valid_nx  = par_ok;
                        perr_nx   = !par_ok;
                        state_nx  = IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        ph_clr   = 1'b1;
                        state_nx = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (tick && rx_s && (phase == PH_LAST))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_valid   <= valid_nx;
            frame_err  <= ferr_nx;
            parity_err <= perr_nx;
            if (load_data)
                rx_data <= shreg;
        end
    end

    always_comb begin
        byte_ext = 8'(rx_data);
        cmd_hit  = 1'b1;
        cmd_code = 3'b000;
        case (byte_ext)
            8'h57:   cmd_code = 3'b011;
            8'h53:   cmd_code = 3'b100;
            8'h41:   cmd_code = 3'b101;
            8'h44:   cmd_code = 3'b110;
            8'h42:   cmd_code = 3'b111;
            8'h31:   cmd_code = 3'b001;
            8'h32:   cmd_code = 3'b010;
            default: cmd_hit  = 1'b0;
        endcase
    end

    // Command register follows rx_valid by one cycle; c_s holds otherwise.
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            c_s        <= 3'b000;
            cmd_strobe <= 1'b0;
        end else begin
            cmd_strobe <= rx_valid && cmd_hit;
            if (rx_valid && cmd_hit)
                c_s <= cmd_code;
        end
    end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Scoreboard bench: an 8N1 receiver (A) and an even-parity receiver (B) with a
// fast divider (DIV=5, 80 clocks per bit) so whole frames fit a short run.
module tb_uart_cmd_receiver;

    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DIV      = 5;
    localparam int CLK_FREQ = BAUD * OS * DIV;
    localparam int BIT      = OS * DIV;

    localparam int K_VALID  = 0;
    localparam int K_FERR   = 1;
    localparam int K_PERR   = 2;
    localparam int K_STROBE = 3;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n_a, rst_n_b, rx_a, rx_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b, frame_err_a, frame_err_b;
    logic       parity_err_a, parity_err_b, cmd_strobe_a, cmd_strobe_b;
    logic [2:0] c_s_a, c_s_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #10 clk = ~clk;

    uart_cmd_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                        .DATA_BITS(8), .PARITY(0)) dut_a (
        .inclk(clk), .rst_n(rst_n_a), .Rx(rx_a), .rx_data(rx_data_a),
        .rx_valid(rx_valid_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
        .c_s(c_s_a), .cmd_strobe(cmd_strobe_a));

    uart_cmd_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                        .DATA_BITS(8), .PARITY(2)) dut_b (
        .inclk(clk), .rst_n(rst_n_b), .Rx(rx_b), .rx_data(rx_data_b),
        .rx_valid(rx_valid_b), .frame_err(frame_err_b), .parity_err(parity_err_b),
        .c_s(c_s_b), .cmd_strobe(cmd_strobe_b));

    function automatic int qsize(input int dut);
        return (dut == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic check_output(input string name, input logic [7:0] got,
                                input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic pop_check(input int dut, input int kind, input logic [7:0] val);
        exp_t e;
        n_cmp++;
        if (qsize(dut) == 0) begin
            n_err++;
            $display("[TB] FAIL unexpected pulse dut%0d: kind %0d value 0x%0h, expected none",
                     dut, kind, val);
            return;
        end
        if (dut == 0) e = q_a.pop_front();
        else          e = q_b.pop_front();
        if ((e.kind != kind) || (e.val !== val)) begin
            n_err++;
            $display("[TB] FAIL pulse dut%0d: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                     dut, kind, val, e.kind, e.val);
        end
    endtask

    // Monitor: every pulse output consumes one expected event in order.
    always @(negedge clk) begin
        if (rx_valid_a)   pop_check(0, K_VALID, rx_data_a);
        if (frame_err_a)  pop_check(0, K_FERR, rx_data_a);
        if (parity_err_a) pop_check(0, K_PERR, rx_data_a);
        if (cmd_strobe_a) pop_check(0, K_STROBE, {5'b0, c_s_a});
        if (rx_valid_b)   pop_check(1, K_VALID, rx_data_b);
        if (frame_err_b)  pop_check(1, K_FERR, rx_data_b);
        if (parity_err_b) pop_check(1, K_PERR, rx_data_b);
        if (cmd_strobe_b) pop_check(1, K_STROBE, {5'b0, c_s_b});
    end

    task automatic expect_evt(input int dut, input int kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        if (dut == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    task automatic drive(input int dut, input logic b, input int n);
        if (dut == 0) rx_a = b;
        else          rx_b = b;
        repeat (n) @(posedge clk);
    endtask

    task automatic apply_stimulus(input int dut, input logic [7:0] data,
                                  input int mode, input logic flip_par,
                                  input logic stop_val);
        logic p;
        drive(dut, 1'b0, BIT);
        for (int i = 0; i < 8; i++)
            drive(dut, data[i], BIT);
        if (mode != 0) begin
            p = (mode == 2) ? (^data) : ~(^data);
            drive(dut, p ^ flip_par, BIT);
        end
        drive(dut, stop_val, BIT);
    endtask

    task automatic drain(input int dut, input string name);
        int n = 0;
        while ((qsize(dut) != 0) && (n < 4 * BIT)) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (qsize(dut) != 0) begin
            n_err++;
            $display("[TB] FAIL %s: %0d expected pulses never seen, expected 0 pending",
                     name, qsize(dut));
            if (dut == 0) q_a.delete();
            else          q_b.delete();
        end
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rx_a = 1'b1;
        rx_b = 1'b1;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("reset c_s A", {5'b0, c_s_a}, 8'h00);
        check_output("reset rx_data A", rx_data_a, 8'h00);
        check_output("reset pulses A",
                     {4'b0, rx_valid_a, frame_err_a, parity_err_a, cmd_strobe_a}, 8'h00);
        check_output("reset c_s B", {5'b0, c_s_b}, 8'h00);
        @(posedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (2 * BIT) @(posedge clk);

        // Even-parity receiver: good 0x31, good 0x57, then 0x31 with bad parity.
        expect_evt(1, K_VALID, 8'h31);
        expect_evt(1, K_STROBE, 8'h01);
        apply_stimulus(1, 8'h31, 2, 1'b0, 1'b1);
        drain(1, "B 0x31 good");
        check_output("B c_s after 0x31", {5'b0, c_s_b}, 8'h01);
        expect_evt(1, K_VALID, 8'h57);
        expect_evt(1, K_STROBE, 8'h03);
        apply_stimulus(1, 8'h57, 2, 1'b0, 1'b1);
        drain(1, "B 0x57 good");
        check_output("B c_s after 0x57", {5'b0, c_s_b}, 8'h03);
        expect_evt(1, K_PERR, 8'h31);
        apply_stimulus(1, 8'h31, 2, 1'b1, 1'b1);
        drain(1, "B 0x31 bad parity");
        check_output("B rx_data after parity error", rx_data_b, 8'h31);
        check_output("B c_s held after parity error", {5'b0, c_s_b}, 8'h03);

        // 8N1 receiver: plain command byte.
        expect_evt(0, K_VALID, 8'h57);
        expect_evt(0, K_STROBE, 8'h03);
        apply_stimulus(0, 8'h57, 0, 1'b0, 1'b1);
        drain(0, "A 0x57");
        check_output("A c_s after 0x57", {5'b0, c_s_a}, 8'h03);
        check_output("A rx_data after 0x57", rx_data_a, 8'h57);

        // Short low glitch on an idle line must be rejected silently.
        drive(0, 1'b0, 15);
        drive(0, 1'b1, 2 * BIT);
        check_output("A c_s after glitch", {5'b0, c_s_a}, 8'h03);

        // Bad stop bit followed by a 3-bit break: one frame error, data held.
        expect_evt(0, K_FERR, 8'h57);
        apply_stimulus(0, 8'h41, 0, 1'b0, 1'b0);
        drive(0, 1'b0, 3 * BIT);
        drive(0, 1'b1, 2 * BIT);
        drain(0, "A framing error");
        check_output("A c_s after framing error", {5'b0, c_s_a}, 8'h03);
        check_output("A rx_data after framing error", rx_data_a, 8'h57);
        expect_evt(0, K_VALID, 8'h44);
        expect_evt(0, K_STROBE, 8'h06);
        apply_stimulus(0, 8'h44, 0, 1'b0, 1'b1);
        drain(0, "A 0x44");
        check_output("A c_s after 0x44", {5'b0, c_s_a}, 8'h06);

        // Back-to-back frames; 0x58 is unmapped so no strobe between.
        expect_evt(0, K_VALID, 8'h42);
        expect_evt(0, K_STROBE, 8'h07);
        expect_evt(0, K_VALID, 8'h58);
        expect_evt(0, K_VALID, 8'h32);
        expect_evt(0, K_STROBE, 8'h02);
        apply_stimulus(0, 8'h42, 0, 1'b0, 1'b1);
        apply_stimulus(0, 8'h58, 0, 1'b0, 1'b1);
        apply_stimulus(0, 8'h32, 0, 1'b0, 1'b1);
        drive(0, 1'b1, BIT);
        drain(0, "A back-to-back");
        check_output("A c_s after back-to-back", {5'b0, c_s_a}, 8'h02);

        // Reset in the middle of the data bits of an all-ones frame.
        drive(0, 1'b0, BIT);
        drive(0, 1'b1, 3 * BIT + BIT / 2);
        rst_n_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("A c_s during reset", {5'b0, c_s_a}, 8'h00);
        check_output("A rx_data during reset", rx_data_a, 8'h00);
        @(posedge clk);
        rst_n_a = 1'b1;
        drive(0, 1'b1, 6 * BIT);
        check_output("A c_s after abort", {5'b0, c_s_a}, 8'h00);
        expect_evt(0, K_VALID, 8'h53);
        expect_evt(0, K_STROBE, 8'h04);
        apply_stimulus(0, 8'h53, 0, 1'b0, 1'b1);
        drain(0, "A 0x53 after reset");
        check_output("A c_s after 0x53", {5'b0, c_s_a}, 8'h04);

        repeat (2 * BIT) @(posedge clk);
        drain(0, "A final");
        drain(1, "B final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_receiver.md
UART_CMD_RECEIVER -- requirements
Module: uart_cmd_receiver

Interface
REQ-001 Parameter CLK_FREQ, 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, serial bit rate.
REQ-003 Parameter OVERSAMPLE, 16, sample ticks per bit; even value, 8..32.
REQ-004 Parameter DATA_BITS, 8, data bits per frame; range 5..8.
REQ-005 Parameter PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 Port inclk, input, 1, the single system clock; all logic on its rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port Rx, input, 1, asynchronous serial line; idles high.
REQ-009 Port rx_data, output, DATA_BITS, last received data word, LSB first on the line.
REQ-010 Port rx_valid, output, 1, one-cycle pulse when an error-free frame completes.
REQ-011 Port frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-012 Port parity_err, output, 1, one-cycle pulse when the parity bit mismatches (PARITY!=0 only).
REQ-013 Port c_s, output, 3, decoded motion/route command, held between updates.
REQ-014 Port cmd_strobe, output, 1, one-cycle pulse when c_s is written from a recognised byte.

Function
REQ-015 Rx SHALL pass through a 2-flop synchroniser; only the synchronised value is used.
REQ-016 The tick divider SHALL be DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor, and SHALL emit a one-clock tick every DIV clocks, running freely.
REQ-017 State machine SHALL have states IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
REQ-018 IDLE -> START on a synchronised high-to-low transition; the tick phase counter SHALL clear on entry.
REQ-019 In START, at tick OVERSAMPLE/2 the line SHALL be checked; low -> DATA, high -> IDLE (glitch rejected, no outputs).
REQ-020 Each bit value (data, parity, stop) SHALL be the majority of three samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 of that bit.
REQ-021 DATA SHALL capture DATA_BITS bits LSB first into a shift register, then go to PAR if PARITY!=0, else STOP.
REQ-022 In PAR, parity SHALL be odd (PARITY=1) or even (PARITY=2) over data bits plus parity bit; the result is latched for STOP.
REQ-023 In STOP with the stop bit high: rx_data updates; rx_valid pulses if parity is good, else parity_err pulses and rx_data still updates; return to IDLE.
REQ-024 In STOP with the stop bit low: frame_err pulses, rx_data is unchanged, no rx_valid or parity_err, -> WAIT_IDLE.
REQ-025 WAIT_IDLE SHALL stay until the line has been high for one full bit (OVERSAMPLE ticks), then -> IDLE; a line held low (break) gives exactly one frame_err.
REQ-026 All pulse outputs SHALL assert in the clock cycle after the stop-bit majority decision and last exactly one clock.
REQ-027 On rx_valid, the data word zero-extended to 8 bits SHALL map as: 0x57->011, 0x53->100, 0x41->101, 0x44->110, 0x42->111, 0x31->001, 0x32->010.
REQ-028 For a mapped byte, c_s and cmd_strobe SHALL update in the cycle after rx_valid; unmapped or errored bytes leave c_s unchanged and give no strobe.
REQ-029 Back-to-back frames (a start bit directly after the stop bit) SHALL be received without loss.

Reset
REQ-030 While rst_n is low: state=IDLE; divider, phase and bit counters=0; synchroniser flops=1; rx_data=0; c_s=3'b000; every pulse output=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no pulse outputs; after release the receiver SHALL ignore the line until it next sees a falling edge.

Verification (CLK_FREQ=50 MHz, BAUD=9600, OVERSAMPLE=16, so DIV=325 and one bit is 5200 clocks)
REQ-032 8N1 byte 0x57 -> rx_valid one pulse, rx_data=0x57, then c_s=011 with cmd_strobe one cycle later.
REQ-033 Low glitch of 1000 clocks on an idle line -> no pulses, state back at IDLE, c_s unchanged.
REQ-034 Byte 0x41 with the stop bit forced low, then the line held low for 3 bit times -> one frame_err only, c_s unchanged; the next good 0x44 gives c_s=110.
REQ-035 PARITY=2: 0x31 with a correct parity bit -> c_s=001; same byte with the parity bit flipped -> parity_err pulse, rx_data=0x31, c_s unchanged, no strobe.
REQ-036 Back-to-back 0x42, 0x58, 0x32 -> three rx_valid pulses; c_s goes 111, stays 111 for 0x58, then 010; cmd_strobe pulses twice.
REQ-037 rst_n pulsed low in the middle of DATA, then a good 0x53 -> no output from the aborted frame; c_s=000 after reset, then 100.
